// File: rtl/wb_reg_bank.sv
// Wishbone pipelined slave holding N_REGS control registers. It supports byte-lane writes,
// per-register write strobes, an error response for unmapped addresses, and optional write/read pipeline stages.
module wb_reg_bank #(
  parameter int unsigned               N_REGS    = 4,
  parameter int unsigned               ADDR_W    = 4,
  parameter int unsigned               DATA_W    = 32,
  parameter logic [N_REGS*DATA_W-1:0]  RESET_VAL = '0,
  parameter bit                        WR_PIPE   = 1'b1,
  parameter bit                        RD_PIPE   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic [ADDR_W-1:0]          wb_adr_i,
  input  logic [DATA_W/8-1:0]        wb_sel_i,
  input  logic                       wb_we_i,
  input  logic [DATA_W-1:0]          wb_dat_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  output logic                       wb_stall_o,
  output logic [DATA_W-1:0]          wb_dat_o,
  output logic [N_REGS*DATA_W-1:0]   regs_o,
  output logic [N_REGS-1:0]          wstb_o
);

  localparam int unsigned SEL_W = DATA_W / 8;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(N_REGS);
  endfunction

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [N_REGS-1:0] wstb_q, wstb_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              armed_q, armed_d;
  logic              rd_busy_q, rd_busy_d, wr_busy_q, wr_busy_d;

  logic              wv_q;
  logic [ADDR_W-1:0] wadr_q;
  logic [SEL_W-1:0]  wsel_q;
  logic [DATA_W-1:0] wdat_q;
  logic              rv_q, rmap_q;
  logic [DATA_W-1:0] rdat_q;

  logic              en, req_wr, req_rd;
  logic              w_go, r_go, r_map, w_map;
  logic [ADDR_W-1:0] w_adr;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_dat, r_dat, rd_word;

  // armed_q makes a held strobe produce one transaction; en must drop before the next acceptance
  assign en     = wb_cyc_i & wb_stb_i;
  assign req_wr = en & armed_q &  wb_we_i & ~wr_busy_q & ~rd_busy_q;
  assign req_rd = en & armed_q & ~wb_we_i & ~rd_busy_q & ~wr_busy_q;

  assign w_go  = WR_PIPE ? wv_q   : req_wr;
  assign w_adr = WR_PIPE ? wadr_q : wb_adr_i;
  assign w_sel = WR_PIPE ? wsel_q : wb_sel_i;
  assign w_dat = WR_PIPE ? wdat_q : wb_dat_i;
  assign w_map = is_mapped(w_adr);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < int'(N_REGS); k++)
      if (wb_adr_i == ADDR_W'(k)) rd_word = regs_q[k];
  end

  assign r_go  = RD_PIPE ? rv_q   : req_rd;
  assign r_map = RD_PIPE ? rmap_q : is_mapped(wb_adr_i);
  assign r_dat = RD_PIPE ? rdat_q : rd_word;

  always_comb begin
    for (int k = 0; k < int'(N_REGS); k++) regs_d[k] = regs_q[k];
    wstb_d = '0;
    if (w_go && w_map) begin
      for (int k = 0; k < int'(N_REGS); k++) begin
        if (w_adr == ADDR_W'(k)) begin
          for (int b = 0; b < int'(SEL_W); b++)
            if (w_sel[b]) regs_d[k][8*b +: 8] = w_dat[8*b +: 8];
          wstb_d[k] = |w_sel;
        end
      end
    end
  end

  always_comb begin
    ack_d = (w_go & w_map) | (r_go & r_map);
    err_d = (w_go & ~w_map) | (r_go & ~r_map);
    dat_d = r_go ? r_dat : dat_q;
    armed_d = armed_q;
    if (!en) armed_d = 1'b1;
    else if (req_wr || req_rd) armed_d = 1'b0;
    wr_busy_d = wr_busy_q;
    rd_busy_d = rd_busy_q;
    if (ack_q || err_q) begin
      wr_busy_d = 1'b0;
      rd_busy_d = 1'b0;
    end
    if (req_wr) wr_busy_d = 1'b1;
    if (req_rd) rd_busy_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(N_REGS); k++) regs_q[k] <= RESET_VAL[k*DATA_W +: DATA_W];
      wstb_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      armed_q   <= 1'b1;
      rd_busy_q <= 1'b0;
      wr_busy_q <= 1'b0;
      wv_q      <= 1'b0;
      wadr_q    <= '0;
      wsel_q    <= '0;
      wdat_q    <= '0;
      rv_q      <= 1'b0;
      rmap_q    <= 1'b0;
      rdat_q    <= '0;
    end else begin
      for (int k = 0; k < int'(N_REGS); k++) regs_q[k] <= regs_d[k];
      wstb_q    <= wstb_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      armed_q   <= armed_d;
      rd_busy_q <= rd_busy_d;
      wr_busy_q <= wr_busy_d;
      wv_q      <= req_wr;
      if (req_wr) begin
        wadr_q <= wb_adr_i;
        wsel_q <= wb_sel_i;
        wdat_q <= wb_dat_i;
      end
      rv_q <= req_rd;
      if (req_rd) begin
        rmap_q <= is_mapped(wb_adr_i);
        rdat_q <= rd_word;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N_REGS); k++) regs_o[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign wstb_o     = wstb_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = en & ~(ack_q | err_q);

endmodule

// File: tb/tb_wb_reg_bank.sv
// Bench for wb_reg_bank: two instances run side by side, one with both pipe stages and one with neither.
// Both receive the same bus stimulus and are checked against a table-driven scoreboard.
module tb_wb_reg_bank;

  localparam logic [127:0] RV = {32'hFFFFFFFF, 32'h12345678, 32'h00000000, 32'hDEADBEEF};
  localparam int LAT0 = 2;  // u_p: WR_PIPE=1, RD_PIPE=1
  localparam int LAT1 = 1;  // u_n: WR_PIPE=0, RD_PIPE=0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we;
  logic [3:0]  adr, sel;
  logic [31:0] wdat;
  logic [1:0]  ack, err, rty, stall;
  logic [31:0] dat  [2];
  logic [127:0] regs [2];
  logic [3:0]  wstb [2];

  wb_reg_bank #(.N_REGS(4), .ADDR_W(4), .DATA_W(32), .RESET_VAL(RV), .WR_PIPE(1'b1), .RD_PIPE(1'b1)) u_p (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]),
    .wb_stall_o(stall[0]), .wb_dat_o(dat[0]), .regs_o(regs[0]), .wstb_o(wstb[0]));

  wb_reg_bank #(.N_REGS(4), .ADDR_W(4), .DATA_W(32), .RESET_VAL(RV), .WR_PIPE(1'b0), .RD_PIPE(1'b0)) u_n (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]),
    .wb_stall_o(stall[1]), .wb_dat_o(dat[1]), .regs_o(regs[1]), .wstb_o(wstb[1]));

  typedef struct {
    logic         we;
    logic [3:0]   adr;
    logic [3:0]   sel;
    logic [31:0]  d;
    int           hold;
    logic         e_err;
    logic [31:0]  e_dat;
    logic [127:0] e_regs;
    logic [3:0]   e_wstb;
  } vec_t;

  typedef struct {
    logic         we;
    logic         err;
    logic [31:0]  dat;
    logic [127:0] regs;
    logic [3:0]   wstb;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run(input vec_t v, input string tag);
    exp_t e;
    int lat[2], cnt[2], wcnt[2], wcyc[2];
    logic [3:0] wv[2];
    logic [31:0] dv[2];
    logic iserr[2];
    int lat_exp[2];
    lat_exp[0] = LAT0;
    lat_exp[1] = LAT1;
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; cnt[i] = 0; wcnt[i] = 0; wcyc[i] = 0; wv[i] = '0; dv[i] = '0; iserr[i] = 1'b0;
    end
    @(negedge clk);
    we = v.we; adr = v.adr; sel = v.sel; wdat = v.d; cyc = 1'b1; stb = 1'b1;
    sb.push_back('{v.we, v.e_err, v.e_dat, v.e_regs, v.e_wstb});
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("%s/u%0d stall@T", tag, i), 128'(stall[i]), 128'd1);
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ack[i] || err[i]) begin
          cnt[i]++;
          if (lat[i] == 0) begin
            lat[i] = s; iserr[i] = err[i]; dv[i] = dat[i];
            chk($sformatf("%s/u%0d stall@ack", tag, i), 128'(stall[i]), 128'd0);
          end
        end else if (stb && lat[i] == 0) begin
          chk($sformatf("%s/u%0d stall@T+%0d", tag, i, s), 128'(stall[i]), 128'd1);
        end
        if (wstb[i] != 4'b0) begin wcnt[i]++; wv[i] |= wstb[i]; wcyc[i] = s; end
      end
      if (s >= v.hold) begin cyc = 1'b0; stb = 1'b0; end
    end
    e = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s/u%0d latency", tag, i), 128'(lat[i]), 128'(lat_exp[i]));
      chk($sformatf("%s/u%0d err", tag, i), 128'(iserr[i]), 128'(e.err));
      chk($sformatf("%s/u%0d completions", tag, i), 128'(cnt[i]), 128'd1);
      if (!e.we) chk($sformatf("%s/u%0d rdata", tag, i), 128'(dv[i]), 128'(e.dat));
      chk($sformatf("%s/u%0d regs", tag, i), regs[i], e.regs);
      chk($sformatf("%s/u%0d wstb", tag, i), 128'(wv[i]), 128'(e.wstb));
      chk($sformatf("%s/u%0d wstb_pulses", tag, i), 128'(wcnt[i]), (e.wstb != 4'b0) ? 128'd1 : 128'd0);
      if (e.wstb != 4'b0)
        chk($sformatf("%s/u%0d wstb_cycle", tag, i), 128'(wcyc[i]), 128'(lat_exp[i]));
    end
  endtask

  localparam logic [127:0] R1 = {32'hFFFFFFFF, 32'h12345678, 32'h00BB00DD, 32'hDEADBEEF};
  localparam logic [127:0] R2 = {32'hFFFFFFFF, 32'h12345678, 32'h00BB00DD, 32'hCAADBEEF};
  localparam logic [127:0] R3 = {32'h00000000, 32'h12345678, 32'h00BB00DD, 32'hCAADBEEF};
  localparam logic [127:0] R4 = {32'hFFFFFFFF, 32'h0BADF00D, 32'h00000000, 32'hDEADBEEF};

  vec_t tbl [11];
  vec_t vr;

  initial begin
    int ack_seen;
    // Expected values below are worked out by hand from the reset image and the write history.
    tbl[0]  = '{1'b1, 4'd1, 4'b0101, 32'hAABBCCDD, 6, 1'b0, 32'h0,        R1, 4'b0010};
    tbl[1]  = '{1'b1, 4'd1, 4'b0000, 32'h11223344, 3, 1'b0, 32'h0,        R1, 4'b0000};
    tbl[2]  = '{1'b0, 4'd2, 4'b0000, 32'h0,        3, 1'b0, 32'h12345678, R1, 4'b0000};
    tbl[3]  = '{1'b0, 4'd1, 4'b1111, 32'h0,        3, 1'b0, 32'h00BB00DD, R1, 4'b0000};
    tbl[4]  = '{1'b0, 4'd7, 4'b1111, 32'h0,        3, 1'b1, 32'h0,        R1, 4'b0000};
    tbl[5]  = '{1'b1, 4'd7, 4'b1111, 32'h55555555, 3, 1'b1, 32'h0,        R1, 4'b0000};
    tbl[6]  = '{1'b1, 4'd0, 4'b1000, 32'hCAFEF00D, 3, 1'b0, 32'h0,        R2, 4'b0001};
    tbl[7]  = '{1'b0, 4'd0, 4'b0000, 32'h0,        3, 1'b0, 32'hCAADBEEF, R2, 4'b0000};
    tbl[8]  = '{1'b1, 4'd3, 4'b1111, 32'h0,        1, 1'b0, 32'h0,        R3, 4'b1000};
    tbl[9]  = '{1'b0, 4'd3, 4'b1111, 32'h0,        3, 1'b0, 32'h0,        R3, 4'b0000};
    tbl[10] = '{1'b0, 4'd4, 4'b1111, 32'h0,        3, 1'b1, 32'h0,        R3, 4'b0000};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; wdat = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset/u%0d regs", i), regs[i], RV);
      chk($sformatf("reset/u%0d ack", i), 128'(ack[i]), 128'd0);
      chk($sformatf("reset/u%0d err", i), 128'(err[i]), 128'd0);
      chk($sformatf("reset/u%0d wstb", i), 128'(wstb[i]), 128'd0);
      chk($sformatf("reset/u%0d dat", i), 128'(dat[i]), 128'd0);
      chk($sformatf("reset/u%0d rty", i), 128'(rty[i]), 128'd0);
    end
    rst = 1'b0;

    for (int k = 0; k < 11; k++) run(tbl[k], $sformatf("vec%0d", k));

    // Reset lands on the edge where u_p would apply its staged write.
    @(negedge clk);
    we = 1'b1; adr = 4'd2; sel = 4'b1111; wdat = 32'h0BADF00D; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    ack_seen = int'(ack[0]) + int'(err[0]);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 5; s++) begin
      ack_seen += int'(ack[0]) + int'(err[0]) + int'(wstb[0] != 4'b0);
      @(negedge clk);
    end
    chk("midrst/u0 no_completion", 128'(ack_seen), 128'd0);
    chk("midrst/u0 regs", regs[0], RV);
    chk("midrst/u1 regs", regs[1], RV);

    vr = '{1'b1, 4'd2, 4'b1111, 32'h0BADF00D, 3, 1'b0, 32'h0, R4, 4'b0100};
    run(vr, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
